// File: rtl/ssd_pkg.sv
// ssd_pkg: shared FSM states, segment table and digit types for the seven-segment scan path
package ssd_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] nibble_t;
    // abcdefg, active-low, a in bit 6
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;
endpackage

// File: rtl/ssd_pattern_decode.sv
// ssd_pattern_decode: maps an active-low abcdefg pattern back to its hex nibble
module ssd_pattern_decode
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);
    always_comb begin
        valid  = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: valid  = 1'b0;
        endcase
    end
endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: rebuilds the four displayed hex digits from the multiplexed anode/cathode pins
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  an,
    input  logic [7:0]  cathodes,
    input  logic        err_clr,
    output logic [15:0] digit_val,
    output logic [3:0]  dp_val,
    output logic [3:0]  digit_valid,
    output logic        frame_pulse,
    output logic        err_anode,
    output logic        err_pattern
);
    localparam int CW = $clog2(SETTLE_CYCLES);

    logic [SYNC_STAGES-1:0][15:0] sync_q;
    logic [15:0] s;
    logic [15:0] s_prev;
    state_t      state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [3:0]  seen;
    logic [3:0]  seen_nxt;
    logic        changed;
    logic        settle_done;
    logic        is_sel;
    logic        is_none;
    digit_idx_t  sel_idx;
    logic        dec_valid;
    nibble_t     dec_nib;
    logic        cap;
    logic        pat_err;
    logic        an_err;

    ssd_pattern_decode u_dec (
        .seg    (s[7:1]),
        .valid  (dec_valid),
        .nibble (dec_nib)
    );

    assign s        = sync_q[SYNC_STAGES-1];
    assign changed  = s != s_prev;
    assign cnt_inc  = cnt + 1'b1;
    assign is_none  = s[15:8] == 8'hFF;
    assign is_sel   = (s[15:12] == 4'hF) && (s[11:8] inside {4'hE, 4'hD, 4'hB, 4'h7});
    assign sel_idx  = !s[8] ? 2'd0 : !s[9] ? 2'd1 : !s[10] ? 2'd2 : 2'd3;
    // the capture edge is the one on which the stable count reaches SETTLE_CYCLES-1
    assign settle_done = (state == SETTLE) && !changed && (cnt_inc == CW'(SETTLE_CYCLES - 1));
    assign cap      = settle_done && is_sel && dec_valid;
    assign pat_err  = settle_done && is_sel && !dec_valid;
    assign an_err   = settle_done && !is_sel && !is_none;
    assign seen_nxt = seen | (cap ? 4'b0001 << sel_idx : 4'b0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            s_prev      <= '1;
            state       <= IDLE;
            cnt         <= '0;
            digit_val   <= '0;
            dp_val      <= '0;
            digit_valid <= '0;
            seen        <= '0;
            frame_pulse <= 1'b0;
            err_anode   <= 1'b0;
            err_pattern <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], an, cathodes};
            s_prev      <= s;
            frame_pulse <= &seen_nxt;
            seen        <= &seen_nxt ? 4'b0000 : seen_nxt;
            err_anode   <= an_err | (err_anode & ~err_clr);
            err_pattern <= pat_err | (err_pattern & ~err_clr);
            if (cap) begin
                digit_val[{sel_idx, 2'b00} +: 4] <= dec_nib;
                dp_val[sel_idx]                  <= ~s[0];
                digit_valid[sel_idx]             <= 1'b1;
            end
            if (changed) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end
                    SETTLE: begin
                        cnt <= cnt_inc;
                        if (settle_done) state <= HOLD;
                    end
                    HOLD:    state <= HOLD;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: directed checks of capture latency, glitch rejection, errors and framing
module tb_ssd_scan_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  an = 8'hFF;
    logic [7:0]  cathodes = 8'hFF;
    logic [15:0] digit_val;
    logic [3:0]  dp_val;
    logic [3:0]  digit_valid;
    logic        frame_pulse;
    logic        err_anode;
    logic        err_pattern;
    int n_cmp = 0;
    int n_bad = 0;
    int fp_cnt = 0;

    always #5 clk = ~clk;

    ssd_scan_decoder #(.SYNC_STAGES(2), .SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .cathodes    (cathodes),
        .err_clr     (err_clr),
        .digit_val   (digit_val),
        .dp_val      (dp_val),
        .digit_valid (digit_valid),
        .frame_pulse (frame_pulse),
        .err_anode   (err_anode),
        .err_pattern (err_pattern)
    );

    always @(negedge clk) if (frame_pulse) fp_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] c, input int n);
        an = a;
        cathodes = c;
        tick(n);
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_digit", digit_val, 16'h0);
        chk("rst_dp", dp_val, 4'h0);
        chk("rst_valid", digit_valid, 4'h0);
        chk("rst_errs", {frame_pulse, err_anode, err_pattern}, 3'b000);
        rst_n = 1'b1;
        // digit 3 with dp lit on slot 0; capture lands exactly 6 edges after the first sampling edge
        drive(8'hFE, 8'h0C, 6);
        chk("lat_early", digit_valid, 4'h0);
        tick(1);
        chk("lat_digit", digit_val[3:0], 4'h3);
        chk("lat_dp", dp_val, 4'h1);
        chk("lat_valid", digit_valid, 4'h1);
        chk("lat_errs", {err_anode, err_pattern}, 2'b00);
        // scan 1,2,3,4
        drive(8'hFE, 8'h9F, 20);
        drive(8'hFD, 8'h25, 20);
        drive(8'hFB, 8'h0D, 20);
        drive(8'hF7, 8'h99, 6);
        chk("fp_early", frame_pulse, 1'b0);
        chk("d3_early", digit_val[15:12], 4'h0);
        tick(1);
        chk("fp_edge", frame_pulse, 1'b1);
        chk("scan_val", digit_val, 16'h4321);
        tick(1);
        chk("fp_width", frame_pulse, 1'b0);
        tick(12);
        chk("fp_count1", fp_cnt, 1);
        chk("scan_dp", dp_val, 4'h0);
        chk("scan_valid", digit_valid, 4'hF);
        // glitching cathodes on slot 1 never settle
        for (int i = 0; i < 4; i++) begin
            drive(8'hFD, 8'h9E, 3);
            drive(8'hFD, 8'h24, 3);
        end
        chk("glitch_dp", dp_val, 4'h0);
        chk("glitch_val", digit_val, 16'h4321);
        tick(20);
        chk("steady_dp", dp_val, 4'h2);
        chk("steady_val", digit_val, 16'h4321);
        chk("steady_fp", fp_cnt, 1);
        // illegal anodes
        drive(8'hFC, 8'h9F, 20);
        chk("anode_err", err_anode, 1'b1);
        chk("anode_val", digit_val, 16'h4321);
        chk("anode_pat", err_pattern, 1'b0);
        clr_pulse();
        chk("anode_clr", err_anode, 1'b0);
        tick(10);
        chk("anode_once", err_anode, 1'b0);
        drive(8'h7E, 8'h9F, 6);
        chk("hi_anode_early", err_anode, 1'b0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_beats_clr", err_anode, 1'b1);
        clr_pulse();
        chk("hi_anode_clr", err_anode, 1'b0);
        chk("anode_valid", digit_valid, 4'hF);
        // invalid segments after a fresh reset
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        drive(8'hFB, 8'hFE, 20);
        chk("pat_err", err_pattern, 1'b1);
        chk("pat_slot", digit_val, 16'h0);
        chk("pat_valid", digit_valid, 4'h0);
        chk("pat_anode", err_anode, 1'b0);
        clr_pulse();
        chk("pat_clr", err_pattern, 1'b0);
        // reset mid-SETTLE with a half-built frame
        drive(8'hFE, 8'h11, 20);
        drive(8'hFD, 8'hC1, 20);
        chk("half_valid", digit_valid, 4'h3);
        drive(8'hFB, 8'h61, 3);
        rst_n = 1'b0;
        #1;
        chk("async_val", digit_val, 16'h0);
        chk("async_rest", {dp_val, digit_valid, frame_pulse, err_anode, err_pattern}, 11'h0);
        tick(2);
        rst_n = 1'b1;
        drive(8'hFE, 8'h11, 20);
        drive(8'hFD, 8'hC1, 20);
        drive(8'hFB, 8'h61, 20);
        drive(8'hF7, 8'h71, 20);
        chk("final_val", digit_val, 16'hFEBA);
        chk("final_valid", digit_valid, 4'hF);
        chk("final_fp", fp_cnt, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
